instr_fetch_unit: RTL

//  Fetch stage directly upstream of the control/decode logic. Holds the PC, requests instructions from

---
 rtl/rv32_fetch_pkg.sv | 30 +++
 rtl/instr_fetch_unit.sv | 102 ++++++++++
 2 files changed

// File: rtl/rv32_fetch_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, reset/NOP defaults,
// and the opcode[6:2] values that control logic decodes.
package rv32_fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013; // addi x0,x0,0

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_I      = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;

  // Sequential fetch address; 32-bit add wraps 0xFFFF_FFFC to 0.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem request, one-entry instruction
// buffer feeding decode, redirect/flush and sticky misaligned-target fault.
module instr_fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
)(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [4:0]  op_code,
  output logic [2:0]  func3,
  output logic        func7_30,
  output logic        misalign_fault
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         req_hs;
  logic         consume;
  logic         redir;
  logic         redir_mis;
  logic         pending;

  // A new request only goes out when the buffer will be free by response time.
  assign imem_req_valid = !rst && (state == REQ) && (!inst_valid || !stall);
  assign imem_req_addr  = pc;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign consume        = inst_valid && !stall;
  assign redir          = redirect_valid && (state != FAULT);
  assign redir_mis      = redir && (redirect_pc[1:0] != 2'b00);

  // Decode fields are plain slices of the buffered word.
  assign op_code  = inst[6:2];
  assign func3    = inst[14:12];
  assign func7_30 = inst[30];

  // Is a request still outstanding once this cycle completes?
  always_comb begin
    pending = 1'b0;
    case (state)
      REQ:         pending = req_hs;
      WAIT, DRAIN: pending = !imem_rsp_valid;
      default:     pending = 1'b0;
    endcase
  end

  // PC, buffer and FSM update; redirect overrides everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= REQ;
      pc             <= RESET_PC;
      inst_valid     <= 1'b0;
      inst           <= NOP_INSTR;
      inst_pc        <= 32'h0;
      misalign_fault <= 1'b0;
    end else if (redir) begin
      // Flush; any response arriving this cycle is dropped.
      pc         <= redirect_pc;
      inst_valid <= 1'b0;
      inst       <= NOP_INSTR;
      if (redir_mis) begin
        misalign_fault <= 1'b1;
        state          <= FAULT;
      end else begin
        state <= pending ? DRAIN : REQ;
      end
    end else begin
      if (consume) begin
        inst_valid <= 1'b0;
        inst       <= NOP_INSTR;
      end
      case (state)
        REQ:   if (req_hs) state <= WAIT;
        WAIT: begin
          if (imem_rsp_valid) begin
            inst       <= imem_rsp_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            pc         <= next_pc(pc);
            state      <= REQ;
          end
        end
        // Stale response from before the redirect is swallowed here.
        DRAIN: if (imem_rsp_valid) state <= REQ;
        default: ;
      endcase
    end
  end

endmodule
